// File: rtl/l2_req_arb_pkg.sv
// l2_req_arb_pkg: shared memory request/response types and arbiter constants.
//   t_mem_req_pkt  : request payload presented by fe/mem clients toward l2
//   t_mem_rsp_pkt  : response payload returned by l2
//   t_arb_src_id   : client index wide enough for the largest supported arbiter
package l2_req_arb_pkg;

  localparam int L2_ARB_MAX_REQ = 16;
  localparam int ARB_SRC_W      = $clog2(L2_ARB_MAX_REQ);

  typedef logic [ARB_SRC_W-1:0] t_arb_src_id;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } t_mem_req_pkt;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } t_mem_rsp_pkt;

endpackage

// File: rtl/l2_req_arb_rr_pick.sv
// l2_req_arb_rr_pick: combinational one-of-N picker.
//   elig : candidate vector
//   ptr  : search start index (round-robin mode only)
//   gnt  : one-hot winner, zero when nothing is eligible
//   win  : winner index
//   any  : at least one candidate was eligible
// ARB_RR=1 searches cyclically from ptr; ARB_RR=0 takes the lowest index.
module l2_req_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ARB_RR  = 1,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      win,
  output logic               any
);

  int idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (ARB_RR != 0) ? ((int'(ptr) + j) % NUM_REQ) : j;
      if (!any && elig[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        win      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/l2_req_arb.sv
// l2_req_arb: N-client request arbiter and in-order response router for l2.
//   clk, reset            : core clock, synchronous active-high reset
//   req_valid/req_pkt     : client requests
//   req_ready             : one-hot grant, same cycle as the request
//   l2_req_valid/_pkt     : registered request toward l2, held under backpressure
//   l2_req_ready          : l2 takes the staged request
//   l2_rsp_valid/_pkt     : l2 responses, returned in acceptance order
//   rsp_valid/rsp_pkt     : response routed to the originating client
//   arb_idle              : nothing staged and nothing outstanding
module l2_req_arb
  import l2_req_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int INFLIGHT_DEPTH  = 8,
  parameter int MAX_OUT_PER_REQ = 4,
  parameter int ARB_RR          = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  t_mem_req_pkt [NUM_REQ-1:0] req_pkt,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       l2_req_valid,
  output t_mem_req_pkt               l2_req_pkt,
  input  logic                       l2_req_ready,
  input  logic                       l2_rsp_valid,
  input  t_mem_rsp_pkt               l2_rsp_pkt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output t_mem_rsp_pkt [NUM_REQ-1:0] rsp_pkt,
  output logic                       arb_idle
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int QW = $clog2(INFLIGHT_DEPTH);
  localparam int CW = $clog2(MAX_OUT_PER_REQ + 1);

  logic [IW-1:0]      q_mem [INFLIGHT_DEPTH];
  logic [QW-1:0]      wr_ptr, rd_ptr;
  logic [QW:0]        q_cnt;
  logic               q_empty, q_full;
  logic [IW-1:0]      head;
  logic               rsp_hit;
  logic               stage_free;
  logic [CW-1:0]      out_cnt [NUM_REQ];
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] elig, gnt;
  logic [IW-1:0]      win;
  logic               grant;

  assign q_empty    = (q_cnt == '0);
  assign q_full     = (q_cnt == (QW+1)'(INFLIGHT_DEPTH));
  assign head       = q_mem[rd_ptr];
  assign rsp_hit    = l2_rsp_valid && !q_empty && !reset;
  assign stage_free = !l2_req_valid || l2_req_ready;
  assign arb_idle   = q_empty && !l2_req_valid;
  assign req_ready  = gnt;

  always_comb begin
    rsp_valid = '0;
    if (rsp_hit) rsp_valid[head] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rsp_pkt[i] = l2_rsp_pkt;
  end

  // A client sitting at its cap may still win if its oldest response is
  // being returned this very cycle; the queue-full test stays registered.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && !q_full && stage_free && !reset &&
                ((out_cnt[i] < CW'(MAX_OUT_PER_REQ)) || rsp_valid[i]);
  end

  l2_req_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ARB_RR  (ARB_RR),
    .IW      (IW)
  ) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .win  (win),
    .any  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      l2_req_valid <= 1'b0;
      l2_req_pkt   <= '0;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q_cnt        <= '0;
      for (int i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
    end else begin
      if (grant) begin
        l2_req_valid <= 1'b1;
        l2_req_pkt   <= req_pkt[win];
        rr_ptr       <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        wr_ptr       <= wr_ptr + 1'b1;
      end else if (stage_free) begin
        l2_req_valid <= 1'b0;
      end
      if (rsp_hit) rd_ptr <= rd_ptr + 1'b1;
      case ({grant, rsp_hit})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: ;
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && !rsp_valid[i])      out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (rsp_valid[i] && !gnt[i]) out_cnt[i] <= out_cnt[i] - 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (grant) q_mem[wr_ptr] <= win;
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(l2_rsp_valid && q_empty));
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(gnt[i] && !rsp_valid[i] && out_cnt[i] == CW'(MAX_OUT_PER_REQ)));
        assert (!(rsp_valid[i] && !gnt[i] && out_cnt[i] == '0));
      end
    end
  end

endmodule

// File: tb/tb_l2_req_arb.sv
`timescale 1ns/1ps
module tb_l2_req_arb;
  import l2_req_arb_pkg::*;

  localparam int N = 4;
  localparam int D = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [N-1:0]         req_valid;
  t_mem_req_pkt [N-1:0] req_pkt;
  logic                 l2_req_ready;
  logic [1:0]           rsp_in_v;
  t_mem_rsp_pkt         l2_rsp_pkt;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [N-1:0]         rdy  [2];
  logic                 l2v  [2];
  t_mem_req_pkt         l2p  [2];
  logic [N-1:0]         rspv [2];
  t_mem_rsp_pkt [N-1:0] rspp [2];
  logic                 idle [2];

  l2_req_arb #(.NUM_REQ(N), .INFLIGHT_DEPTH(D), .MAX_OUT_PER_REQ(M), .ARB_RR(1)) u_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pkt(req_pkt),
    .req_ready(rdy[0]), .l2_req_valid(l2v[0]), .l2_req_pkt(l2p[0]),
    .l2_req_ready(l2_req_ready), .l2_rsp_valid(rsp_in_v[0]), .l2_rsp_pkt(l2_rsp_pkt),
    .rsp_valid(rspv[0]), .rsp_pkt(rspp[0]), .arb_idle(idle[0]));

  l2_req_arb #(.NUM_REQ(N), .INFLIGHT_DEPTH(D), .MAX_OUT_PER_REQ(M), .ARB_RR(0)) u_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pkt(req_pkt),
    .req_ready(rdy[1]), .l2_req_valid(l2v[1]), .l2_req_pkt(l2p[1]),
    .l2_req_ready(l2_req_ready), .l2_rsp_valid(rsp_in_v[1]), .l2_rsp_pkt(l2_rsp_pkt),
    .rsp_valid(rspv[1]), .rsp_pkt(rspp[1]), .arb_idle(idle[1]));

  // reference model: order queue of source ids, per-client counts, staged slot
  int           m_q0[$], m_q1[$];
  bit           m_stg_v [2];
  t_mem_req_pkt m_stg_p [2];
  int           m_cnt   [2][N];
  int           m_rr    [2];
  int           m_l2o   [2];

  logic [N-1:0] e_rdy  [2];
  logic [N-1:0] e_rspv [2];
  logic         e_idle [2];
  int           e_win  [2];
  int           e_src  [2];
  bit           e_free [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int q_size(input int k);
    return (k == 0) ? m_q0.size() : m_q1.size();
  endfunction

  function automatic int q_front(input int k);
    return (k == 0) ? m_q0[0] : m_q1[0];
  endfunction

  task automatic q_push(input int k, input int v);
    if (k == 0) m_q0.push_back(v); else m_q1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) void'(m_q0.pop_front()); else void'(m_q1.pop_front());
  endtask

  task automatic model_eval(input int k);
    int qs;
    int i;
    qs = q_size(k);
    e_free[k] = !m_stg_v[k] || l2_req_ready;
    e_src[k]  = -1;
    e_rspv[k] = '0;
    if (!reset && rsp_in_v[k] && qs > 0) begin
      e_src[k] = q_front(k);
      e_rspv[k][e_src[k]] = 1'b1;
    end
    e_win[k] = -1;
    if (!reset && e_free[k] && qs < D) begin
      for (int j = 0; j < N; j++) begin
        i = (k == 0) ? (m_rr[k] + j) % N : j;
        if (e_win[k] < 0 && req_valid[i] && (m_cnt[k][i] - ((i == e_src[k]) ? 1 : 0)) < M)
          e_win[k] = i;
      end
    end
    e_rdy[k] = '0;
    if (e_win[k] >= 0) e_rdy[k][e_win[k]] = 1'b1;
    e_idle[k] = (qs == 0) && !m_stg_v[k];
  endtask

  task automatic model_commit();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        if (k == 0) m_q0.delete(); else m_q1.delete();
        m_stg_v[k] = 1'b0;
        m_rr[k]    = 0;
        m_l2o[k]   = 0;
        for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
      end else begin
        model_eval(k);
        if (m_stg_v[k] && l2_req_ready) m_l2o[k]++;
        if (e_src[k] >= 0) begin
          q_pop(k);
          m_cnt[k][e_src[k]]--;
          m_l2o[k]--;
        end
        if (e_win[k] >= 0) begin
          q_push(k, e_win[k]);
          m_cnt[k][e_win[k]]++;
          m_stg_v[k] = 1'b1;
          m_stg_p[k] = req_pkt[e_win[k]];
          m_rr[k]    = (e_win[k] + 1) % N;
        end else if (e_free[k]) begin
          m_stg_v[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  // Responses are only offered when the model has requests accepted by l2.
  task automatic drive(input logic [N-1:0] rv, input bit rdy_in, input int rsp_pct);
    req_valid = rv;
    for (int i = 0; i < N; i++)
      req_pkt[i] = '{addr: $urandom, wr: 1'($urandom), wdata: $urandom, be: 4'($urandom)};
    l2_req_ready = rdy_in;
    for (int k = 0; k < 2; k++)
      rsp_in_v[k] = (m_l2o[k] > 0) && (int'($urandom_range(99)) < rsp_pct);
    l2_rsp_pkt = '{rdata: $urandom, err: 1'($urandom)};
    #1;
    model_eval(0);
    model_eval(1);
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      drive('0, 1'b1, 100);
      if (e_idle[0] && e_idle[1]) break;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rspv[k] !== e_rspv[k]) begin
          n_bad++;
          $display("FAIL drain_rspv k=%0d got %b want %b", k, rspv[k], e_rspv[k]);
        end
      end
      tick();
    end
    n_cmp++;
    if (idle[0] !== 1'b1 || idle[1] !== 1'b1 || !(e_idle[0] && e_idle[1])) begin
      n_bad++;
      $display("FAIL drain_idle got %b%b want 11", idle[0], idle[1]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive('1, 1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rdy[k] !== '0) begin
        n_bad++;
        $display("FAIL reset_rdy k=%0d got %b want 0000", k, rdy[k]);
      end
    end
    tick();
    tick();
    reset = 1'b0;
    drive('0, 1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (idle[k] !== 1'b1 || l2v[k] !== 1'b0 || rspv[k] !== '0) begin
        n_bad++;
        $display("FAIL reset_state k=%0d got idle=%b l2v=%b rspv=%b want 1 0 0000",
                 k, idle[k], l2v[k], rspv[k]);
      end
    end
  endtask

  task automatic test_rr_alternate();
    logic [N-1:0] want;
    for (int c = 0; c < 8; c++) begin
      drive(4'b0011, 1'b1, 0);
      want = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      n_cmp++;
      if (rdy[0] !== want) begin
        n_bad++;
        $display("FAIL rr_alt_grant c=%0d got %b want %b", c, rdy[0], want);
      end
      n_cmp++;
      if (l2v[0] !== (c > 0)) begin
        n_bad++;
        $display("FAIL rr_alt_l2v c=%0d got %b want %b", c, l2v[0], c > 0);
      end
      n_cmp++;
      if (rdy[1] !== e_rdy[1]) begin
        n_bad++;
        $display("FAIL rr_alt_fp_grant c=%0d got %b want %b", c, rdy[1], e_rdy[1]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_fixed_prio();
    for (int c = 0; c < 10; c++) begin
      drive(4'b1010, 1'b1, 100);
      n_cmp++;
      if (rdy[1] !== 4'b0010) begin
        n_bad++;
        $display("FAIL fp_low_wins c=%0d got %b want 0010", c, rdy[1]);
      end
      n_cmp++;
      if (rspv[1] !== e_rspv[1] || rdy[0] !== e_rdy[0]) begin
        n_bad++;
        $display("FAIL fp_side c=%0d got rspv=%b rr_rdy=%b want %b %b",
                 c, rspv[1], rdy[0], e_rspv[1], e_rdy[0]);
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(4'b1000, 1'b1, 100);
      n_cmp++;
      if (rdy[1] !== 4'b1000) begin
        n_bad++;
        $display("FAIL fp_unstarve c=%0d got %b want 1000", c, rdy[1]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_out_limit();
    int g = 0;
    for (int c = 0; c < 6; c++) begin
      drive(4'b0001, 1'b1, 0);
      if (rdy[1][0]) g++;
      n_cmp++;
      if (rdy[0] !== e_rdy[0]) begin
        n_bad++;
        $display("FAIL limit_rr c=%0d got %b want %b", c, rdy[0], e_rdy[0]);
      end
      tick();
    end
    n_cmp++;
    if (g !== 4) begin
      n_bad++;
      $display("FAIL limit_count got %0d want 4", g);
    end
    drive(4'b0001, 1'b1, 100);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rspv[k] !== 4'b0001 || rdy[k] !== 4'b0001) begin
        n_bad++;
        $display("FAIL limit_rsp_regrant k=%0d got rspv=%b rdy=%b want 0001 0001",
                 k, rspv[k], rdy[k]);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    drive(4'b0001, 1'b1, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0011, 1'b0, 0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (l2v[k] !== 1'b1 || l2p[k] !== m_stg_p[k] || rdy[k] !== '0) begin
          n_bad++;
          $display("FAIL bp_hold k=%0d c=%0d got v=%b pkt=%h rdy=%b want 1 %h 0000",
                   k, c, l2v[k], l2p[k], rdy[k], m_stg_p[k]);
        end
      end
      tick();
    end
    drive(4'b0011, 1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rdy[k] !== e_rdy[k] || rdy[k] === '0) begin
        n_bad++;
        $display("FAIL bp_release k=%0d got %b want %b", k, rdy[k], e_rdy[k]);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_wrap();
    int g = 0;
    int c = 0;
    while (g < 20 && c < 300) begin
      drive({2'b00, 2'($urandom)}, ($urandom_range(3) != 0), 60);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy[k] !== e_rdy[k] || rspv[k] !== e_rspv[k]) begin
          n_bad++;
          $display("FAIL wrap_route k=%0d c=%0d got rdy=%b rspv=%b want %b %b",
                   k, c, rdy[k], rspv[k], e_rdy[k], e_rspv[k]);
        end
      end
      if (e_win[0] >= 0) g++;
      tick();
      c++;
    end
    n_cmp++;
    if (g < 20) begin
      n_bad++;
      $display("FAIL wrap_timeout got %0d grants want 20", g);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom), ($urandom_range(9) < 7), 50);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy[k] !== e_rdy[k] || rspv[k] !== e_rspv[k] || idle[k] !== e_idle[k] ||
            l2v[k] !== m_stg_v[k] || (m_stg_v[k] && l2p[k] !== m_stg_p[k])) begin
          n_bad++;
          $display("FAIL rand k=%0d c=%0d got rdy=%b rspv=%b idle=%b v=%b want %b %b %b %b",
                   k, c, rdy[k], rspv[k], idle[k], l2v[k],
                   e_rdy[k], e_rspv[k], e_idle[k], m_stg_v[k]);
        end
        n_cmp++;
        if (rspp[k][c % N] !== l2_rsp_pkt) begin
          n_bad++;
          $display("FAIL rand_rsp_pkt k=%0d got %h want %h", k, rspp[k][c % N], l2_rsp_pkt);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0011, 1'b1, 0);
      tick();
    end
    reset = 1'b1;
    drive('0, 1'b1, 0);
    tick();
    reset = 1'b0;
    drive('0, 1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (idle[k] !== 1'b1 || l2v[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset_idle k=%0d got idle=%b l2v=%b want 1 0", k, idle[k], l2v[k]);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (u_rr.out_cnt[i] !== '0 || u_fp.out_cnt[i] !== '0) begin
        n_bad++;
        $display("FAIL midreset_cnt i=%0d got %0d %0d want 0 0", i, u_rr.out_cnt[i], u_fp.out_cnt[i]);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_pkt      = '0;
    l2_req_ready = 1'b0;
    rsp_in_v     = '0;
    l2_rsp_pkt   = '0;
    @(negedge clk);
    test_reset();
    test_rr_alternate();
    test_fixed_prio();
    test_out_limit();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
